uart_command_decoder: RTL and testbench

//  Receive side of the host<->board UART link. Consumes bytes from the UART receiver,

---
 rtl/uart_command_decoder.sv | 192 +++++++++++++++++++
 tb/tb_uart_command_decoder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_command_decoder.sv
// uart_command_decoder: frames UART bytes into SYNC/OPCODE/[ARG]/CHK command
// packets, validates them and holds one decoded command for the game FSM.
// Ports:
//   clock, reset                - system clock, async active-high reset
//   rx_valid, rx_data, rx_error - byte stream from the UART receiver
//   cmd_ready                   - game FSM accepts the pending command
//   cmd_valid, cmd_opcode,
//   cmd_arg                     - pending decoded command (held until accepted)
//   bad_packet, overflow        - one-cycle pulses for rejected / dropped packets
//   err_count                   - saturating count of bad_packet pulses
module uart_command_decoder #(
   parameter logic [7:0]  SYNC_BYTE      = 8'hAA,
   parameter int unsigned TIMEOUT_CYCLES = 50000,
   parameter int unsigned ERR_CNT_W      = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 rx_valid,
   input  logic [7:0]           rx_data,
   input  logic                 rx_error,
   input  logic                 cmd_ready,
   output logic                 cmd_valid,
   output logic [2:0]           cmd_opcode,
   output logic [3:0]           cmd_arg,
   output logic                 bad_packet,
   output logic                 overflow,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [2:0] OP_START   = 3'd1;
   localparam logic [2:0] OP_DIFF    = 3'd2;
   localparam logic [2:0] OP_MOVE    = 3'd3;
   localparam logic [2:0] OP_PLACE   = 3'd4;
   localparam logic [2:0] OP_RESTART = 3'd5;

   typedef enum logic [1:0] {
      S_HUNT     = 2'd0,
      S_OPCODE   = 2'd1,
      S_PAYLOAD  = 2'd2,
      S_CHECKSUM = 2'd3
   } state_t;

   state_t               state_q,      state_d;
   logic [2:0]           opcode_q,     opcode_d;
   logic [7:0]           arg_q,        arg_d;
   logic [TMO_W-1:0]     tmo_q,        tmo_d;
   logic                 cmd_valid_q,  cmd_valid_d;
   logic [2:0]           cmd_opcode_q, cmd_opcode_d;
   logic [3:0]           cmd_arg_q,    cmd_arg_d;
   logic                 bad_q,        bad_d;
   logic                 ovf_q,        ovf_d;
   logic [ERR_CNT_W-1:0] err_q,        err_d;

   logic                 good_c;
   logic                 chk_ok_c;
   logic                 arg_ok_c;

   // Checksum and argument-range validation of the packet being closed
   always_comb begin
      chk_ok_c = (rx_data == ({5'b0, opcode_q} ^ arg_q));
      arg_ok_c = 1'b0;
      if (arg_q[7:4] == 4'd0) begin
         case (opcode_q)
            OP_DIFF:  arg_ok_c = (arg_q <= 8'd1);
            OP_MOVE:  arg_ok_c = (arg_q <= 8'd3);
            OP_PLACE: arg_ok_c = (arg_q >= 8'd1) && (arg_q <= 8'd9);
            default:  arg_ok_c = 1'b1;
         endcase
      end
   end

   // Packet framing FSM, timeout, command handshake and error counting
   always_comb begin
      state_d      = state_q;
      opcode_d     = opcode_q;
      arg_d        = arg_q;
      tmo_d        = tmo_q;
      cmd_valid_d  = cmd_valid_q;
      cmd_opcode_d = cmd_opcode_q;
      cmd_arg_d    = cmd_arg_q;
      bad_d        = 1'b0;
      ovf_d        = 1'b0;
      err_d        = err_q;
      good_c       = 1'b0;

      if (rx_valid) begin
         tmo_d = '0;
         if (rx_error) begin
            // corrupted byte: discard; abort only if a packet was in progress
            if (state_q != S_HUNT) begin
               bad_d   = 1'b1;
               state_d = S_HUNT;
            end
         end else begin
            case (state_q)
               S_HUNT: begin
                  if (rx_data == SYNC_BYTE) state_d = S_OPCODE;
               end
               S_OPCODE: begin
                  case (rx_data)
                     8'd1, 8'd5: begin
                        opcode_d = rx_data[2:0];
                        arg_d    = 8'd0;
                        state_d  = S_CHECKSUM;
                     end
                     8'd2, 8'd3, 8'd4: begin
                        opcode_d = rx_data[2:0];
                        state_d  = S_PAYLOAD;
                     end
                     default: begin
                        bad_d   = 1'b1;
                        state_d = S_HUNT;
                     end
                  endcase
               end
               S_PAYLOAD: begin
                  arg_d   = rx_data;
                  state_d = S_CHECKSUM;
               end
               S_CHECKSUM: begin
                  state_d = S_HUNT;
                  if (chk_ok_c && arg_ok_c) good_c = 1'b1;
                  else                      bad_d  = 1'b1;
               end
               default: state_d = S_HUNT;
            endcase
         end
      end else if (state_q != S_HUNT) begin
         if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            bad_d   = 1'b1;
            state_d = S_HUNT;
            tmo_d   = '0;
         end else begin
            tmo_d = tmo_q + TMO_W'(1);
         end
      end else begin
         tmo_d = '0;
      end

      // a completing packet may replace a command being accepted this cycle
      if (good_c) begin
         if (!cmd_valid_q || cmd_ready) begin
            cmd_valid_d  = 1'b1;
            cmd_opcode_d = opcode_q;
            cmd_arg_d    = arg_q[3:0];
         end else begin
            ovf_d = 1'b1;
         end
      end else if (cmd_valid_q && cmd_ready) begin
         cmd_valid_d = 1'b0;
      end

      if (bad_d && (err_q != '1)) err_d = err_q + ERR_CNT_W'(1);
   end

   // State and output registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= S_HUNT;
         opcode_q     <= 3'd0;
         arg_q        <= 8'd0;
         tmo_q        <= '0;
         cmd_valid_q  <= 1'b0;
         cmd_opcode_q <= 3'd0;
         cmd_arg_q    <= 4'd0;
         bad_q        <= 1'b0;
         ovf_q        <= 1'b0;
         err_q        <= '0;
      end else begin
         state_q      <= state_d;
         opcode_q     <= opcode_d;
         arg_q        <= arg_d;
         tmo_q        <= tmo_d;
         cmd_valid_q  <= cmd_valid_d;
         cmd_opcode_q <= cmd_opcode_d;
         cmd_arg_q    <= cmd_arg_d;
         bad_q        <= bad_d;
         ovf_q        <= ovf_d;
         err_q        <= err_d;
      end
   end

   assign cmd_valid  = cmd_valid_q;
   assign cmd_opcode = cmd_opcode_q;
   assign cmd_arg    = cmd_arg_q;
   assign bad_packet = bad_q;
   assign overflow   = ovf_q;
   assign err_count  = err_q;

endmodule

// File: tb/tb_uart_command_decoder.sv
// tb_uart_command_decoder: directed vector table plus hand-written sequences
// for timeout, overflow, simultaneous accept, rx_error, saturation and reset.
module tb_uart_command_decoder;

   localparam int unsigned TMO = 32;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'd0;
   logic       rx_error = 1'b0;
   logic       cmd_ready = 1'b0;
   logic       cmd_valid;
   logic [2:0] cmd_opcode;
   logic [3:0] cmd_arg;
   logic       bad_packet;
   logic       overflow;
   logic [7:0] err_count;

   int total = 0;
   int bad = 0;
   int exp_err = 0;

   uart_command_decoder #(
      .SYNC_BYTE      (8'hAA),
      .TIMEOUT_CYCLES (TMO),
      .ERR_CNT_W      (8)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_error   (rx_error),
      .cmd_ready  (cmd_ready),
      .cmd_valid  (cmd_valid),
      .cmd_opcode (cmd_opcode),
      .cmd_arg    (cmd_arg),
      .bad_packet (bad_packet),
      .overflow   (overflow),
      .err_count  (err_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] bytes;   // first byte in [31:24]
      int          n;
      logic        exp_valid;
      logic [2:0]  exp_op;
      logic [3:0]  exp_arg;
      logic        exp_bad;
   } vec_t;

   vec_t vecs [15];

   function automatic vec_t mk(input logic [31:0] b, input int n, input logic v,
                               input logic [2:0] op, input logic [3:0] arg, input logic bd);
      vec_t r;
      r.bytes = b; r.n = n; r.exp_valid = v; r.exp_op = op; r.exp_arg = arg; r.exp_bad = bd;
      return r;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic err);
      rx_valid = 1'b1;
      rx_data  = b;
      rx_error = err;
      tick();
      rx_valid = 1'b0;
      rx_error = 1'b0;
   endtask

   task automatic note_bad();
      if (exp_err < 255) exp_err++;
   endtask

   task automatic accept();
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] b;
      bit found;
      int waited;

      vecs[0]  = mk(32'hAA010100, 3, 1'b1, 3'd1, 4'd0, 1'b0);
      vecs[1]  = mk(32'hAA040703, 4, 1'b1, 3'd4, 4'd7, 1'b0);
      vecs[2]  = mk(32'hAA040A0E, 4, 1'b0, 3'd0, 4'd0, 1'b1);
      vecs[3]  = mk(32'hAA030200, 4, 1'b0, 3'd0, 4'd0, 1'b1);
      vecs[4]  = mk(32'hAA030201, 4, 1'b1, 3'd3, 4'd2, 1'b0);
      vecs[5]  = mk(32'hAA050500, 3, 1'b1, 3'd5, 4'd0, 1'b0);
      vecs[6]  = mk(32'hAA020103, 4, 1'b1, 3'd2, 4'd1, 1'b0);
      vecs[7]  = mk(32'hAA020200, 4, 1'b0, 3'd0, 4'd0, 1'b1);
      vecs[8]  = mk(32'hAA060000, 2, 1'b0, 3'd0, 4'd0, 1'b1);
      vecs[9]  = mk(32'hAA040004, 4, 1'b0, 3'd0, 4'd0, 1'b1);
      vecs[10] = mk(32'hAA04090D, 4, 1'b1, 3'd4, 4'd9, 1'b0);
      vecs[11] = mk(32'hAA031310, 4, 1'b0, 3'd0, 4'd0, 1'b1);
      vecs[12] = mk(32'h55AA0101, 4, 1'b1, 3'd1, 4'd0, 1'b0);
      vecs[13] = mk(32'hAA03AAA9, 4, 1'b0, 3'd0, 4'd0, 1'b1);
      vecs[14] = mk(32'hAA000000, 2, 1'b0, 3'd0, 4'd0, 1'b1);

      // reset state
      tick();
      tick();
      check("rst_valid", int'(cmd_valid), 0);
      check("rst_opcode", int'(cmd_opcode), 0);
      check("rst_arg", int'(cmd_arg), 0);
      check("rst_bad", int'(bad_packet), 0);
      check("rst_ovf", int'(overflow), 0);
      check("rst_err", int'(err_count), 0);
      reset = 1'b0;
      tick();

      // table-driven packets
      foreach (vecs[i]) begin
         b = vecs[i].bytes;
         for (int j = 0; j < vecs[i].n; j++) send_byte(b[31-8*j -: 8], 1'b0);
         if (vecs[i].exp_bad) note_bad();
         check($sformatf("vec%0d_valid", i), int'(cmd_valid), int'(vecs[i].exp_valid));
         check($sformatf("vec%0d_bad", i), int'(bad_packet), int'(vecs[i].exp_bad));
         check($sformatf("vec%0d_err", i), int'(err_count), exp_err);
         if (vecs[i].exp_valid) begin
            check($sformatf("vec%0d_op", i), int'(cmd_opcode), int'(vecs[i].exp_op));
            check($sformatf("vec%0d_arg", i), int'(cmd_arg), int'(vecs[i].exp_arg));
            tick();
            tick();
            check($sformatf("vec%0d_held", i), int'(cmd_valid), 1);
            check($sformatf("vec%0d_op_held", i), int'(cmd_opcode), int'(vecs[i].exp_op));
            accept();
            check($sformatf("vec%0d_dropped", i), int'(cmd_valid), 0);
         end else begin
            tick();
            check($sformatf("vec%0d_bad_pulse", i), int'(bad_packet), 0);
         end
      end

      // timeout mid-packet, then a normal packet
      send_byte(8'hAA, 1'b0);
      send_byte(8'h02, 1'b0);
      found = 1'b0;
      waited = 0;
      for (int k = 1; k <= int'(TMO) + 8; k++) begin
         tick();
         if (bad_packet && !found) begin
            found = 1'b1;
            waited = k;
         end
         if (found) break;
      end
      note_bad();
      check("tmo_seen", int'(found), 1);
      check("tmo_latency", waited, int'(TMO));
      check("tmo_err", int'(err_count), exp_err);
      send_byte(8'hAA, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h01, 1'b0);
      send_byte(8'h03, 1'b0);
      check("post_tmo_valid", int'(cmd_valid), 1);
      check("post_tmo_op", int'(cmd_opcode), 2);
      check("post_tmo_arg", int'(cmd_arg), 1);
      accept();

      // overflow: second good packet while first pending
      send_byte(8'hAA, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h01, 1'b0);
      send_byte(8'hAA, 1'b0); send_byte(8'h05, 1'b0); send_byte(8'h05, 1'b0);
      check("ovf_pulse", int'(overflow), 1);
      check("ovf_valid", int'(cmd_valid), 1);
      check("ovf_op_kept", int'(cmd_opcode), 1);
      check("ovf_err", int'(err_count), exp_err);
      check("ovf_no_bad", int'(bad_packet), 0);
      tick();
      check("ovf_pulse_end", int'(overflow), 0);

      // ready in the same cycle the next packet completes
      send_byte(8'hAA, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h02, 1'b0);
      cmd_ready = 1'b1;
      send_byte(8'h01, 1'b0);
      cmd_ready = 1'b0;
      check("swap_valid", int'(cmd_valid), 1);
      check("swap_op", int'(cmd_opcode), 3);
      check("swap_arg", int'(cmd_arg), 2);
      check("swap_no_ovf", int'(overflow), 0);
      accept();
      check("swap_accepted", int'(cmd_valid), 0);

      // rx_error in hunt is silent; mid-packet aborts
      send_byte(8'hAA, 1'b1);
      check("err_hunt_no_bad", int'(bad_packet), 0);
      send_byte(8'h01, 1'b0); send_byte(8'h01, 1'b0);
      check("err_hunt_no_cmd", int'(cmd_valid), 0);
      send_byte(8'hAA, 1'b0); send_byte(8'h04, 1'b0); send_byte(8'h07, 1'b1);
      note_bad();
      check("rxerr_bad", int'(bad_packet), 1);
      check("rxerr_err", int'(err_count), exp_err);
      send_byte(8'h03, 1'b0);
      check("rxerr_hunt", int'(cmd_valid), 0);
      send_byte(8'hAA, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h01, 1'b0);
      check("rxerr_recover", int'(cmd_valid), 1);
      accept();

      // saturation
      for (int k = 0; k < 300; k++) begin
         send_byte(8'hAA, 1'b0);
         send_byte(8'h00, 1'b0);
         note_bad();
      end
      tick();
      check("sat_err", int'(err_count), 255);
      check("sat_model", exp_err, 255);

      // reset mid-packet with pending command
      send_byte(8'hAA, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h01, 1'b0);
      send_byte(8'hAA, 1'b0); send_byte(8'h04, 1'b0);
      reset = 1'b1;
      #1;
      check("arst_valid", int'(cmd_valid), 0);
      check("arst_err", int'(err_count), 0);
      tick();
      reset = 1'b0;
      send_byte(8'h07, 1'b0); send_byte(8'h03, 1'b0);
      check("arst_no_cmd", int'(cmd_valid), 0);
      check("arst_no_bad", int'(bad_packet), 0);
      check("arst_no_ovf", int'(overflow), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
